// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register, raised
// at issue and lowered at writeback. Decode stalls while a source or a saturated
// destination still has writes in flight.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                D_valid,
    input  logic [IDX_W-1:0]    D_src1_idx,
    input  logic                D_src1_use,
    input  logic [IDX_W-1:0]    D_src2_idx,
    input  logic                D_src2_use,
    input  logic [IDX_W-1:0]    D_dst_idx,
    input  logic                D_dst_we,
    input  logic                WB_valid,
    input  logic [IDX_W-1:0]    WB_dst_idx,
    input  logic                flush,
    output logic                D_stall,
    output logic                D_issue,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntZero = '0;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                sb_err_q, sb_err_d;

    logic src1_haz, src2_haz, sat_haz;
    logic inc, dec;

    // Hazards look only at registered counters; a retire this cycle does not bypass.
    always_comb begin
        src1_haz = D_src1_use && (cnt_q[D_src1_idx] != CntZero);
        src2_haz = D_src2_use && (cnt_q[D_src2_idx] != CntZero);
        sat_haz  = D_dst_we && (cnt_q[D_dst_idx] == CntMax);
        D_stall  = D_valid && (src1_haz || src2_haz || sat_haz);
        D_issue  = D_valid && !D_stall;
    end

    always_comb begin
        inc       = 1'b0;
        dec       = 1'b0;
        pending_d = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc = D_issue && D_dst_we && (D_dst_idx == IDX_W'(r));
            dec = WB_valid && (WB_dst_idx == IDX_W'(r)) && (cnt_q[r] != CntZero);
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = CntZero;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            pending_d[r] = (cnt_d[r] != CntZero);
        end
        sb_err_d = sb_err_q || (WB_valid && !flush && (cnt_q[WB_dst_idx] == CntZero));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= CntZero;
            end
            pending_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pending_q <= pending_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign pending_mask = pending_q;
    assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stimulus pushes hand-computed expectations into a
// queue, and a negedge monitor pops one entry per cycle and compares the DUT outputs.
module tb_reg_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       D_valid;
    logic [2:0] D_src1_idx;
    logic       D_src1_use;
    logic [2:0] D_src2_idx;
    logic       D_src2_use;
    logic [2:0] D_dst_idx;
    logic       D_dst_we;
    logic       WB_valid;
    logic [2:0] WB_dst_idx;
    logic       flush;
    logic       D_stall;
    logic       D_issue;
    logic [7:0] pending_mask;
    logic       sb_err;

    typedef struct {
        logic       chk;
        int         id;
        logic       stall;
        logic       issue;
        logic [7:0] mask;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step_id = 0;

    reg_scoreboard #(
        .NUM_REGS(8),
        .IDX_W   (3),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .D_valid     (D_valid),
        .D_src1_idx  (D_src1_idx),
        .D_src1_use  (D_src1_use),
        .D_src2_idx  (D_src2_idx),
        .D_src2_use  (D_src2_use),
        .D_dst_idx   (D_dst_idx),
        .D_dst_we    (D_dst_we),
        .WB_valid    (WB_valid),
        .WB_dst_idx  (WB_dst_idx),
        .flush       (flush),
        .D_stall     (D_stall),
        .D_issue     (D_issue),
        .pending_mask(pending_mask),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst_n = 1'b1; D_valid = 1'b0; flush = 1'b0;
        D_src1_idx = 3'd0; D_src1_use = 1'b0; D_src2_idx = 3'd0; D_src2_use = 1'b0;
        D_dst_idx = 3'd0; D_dst_we = 1'b0; WB_valid = 1'b0; WB_dst_idx = 3'd0;
    endtask

    task automatic dec(input logic v, input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2,
                       input logic [2:0] dst, input logic we);
        D_valid = v; D_src1_idx = s1; D_src1_use = u1; D_src2_idx = s2; D_src2_use = u2;
        D_dst_idx = dst; D_dst_we = we;
    endtask

    task automatic wb(input logic [2:0] idx);
        WB_valid = 1'b1; WB_dst_idx = idx;
    endtask

    // Push expectation for the current cycle, then advance one clock.
    task automatic cyc_x(input logic chk, input logic st, input logic is,
                         input logic [7:0] m, input logic e);
        exp_t x;
        step_id++;
        x.chk = chk; x.id = step_id; x.stall = st; x.issue = is; x.mask = m; x.err = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic cyc(input logic st, input logic is, input logic [7:0] m, input logic e);
        cyc_x(1'b1, st, is, m, e);
    endtask

    task automatic cyc_nc();
        cyc_x(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                n_chk += 4;
                if (D_stall === e.stall) n_pass++;
                else $display("FAIL step%0d D_stall got %b want %b", e.id, D_stall, e.stall);
                if (D_issue === e.issue) n_pass++;
                else $display("FAIL step%0d D_issue got %b want %b", e.id, D_issue, e.issue);
                if (pending_mask === e.mask) n_pass++;
                else $display("FAIL step%0d pending_mask got %h want %h", e.id,
                              pending_mask, e.mask);
                if (sb_err === e.err) n_pass++;
                else $display("FAIL step%0d sb_err got %b want %b", e.id, sb_err, e.err);
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle();

        // 1: basic issue, then record visible next cycle
        dec(1, 3'd1, 1, 3'd2, 1, 3'd4, 1);           cyc(0, 1, 8'h00, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd3, 1);           cyc(0, 1, 8'h10, 0);
        // 2: RAW on r3 until retire, released the cycle after WB
        dec(1, 3'd3, 1, 3'd0, 0, 3'd0, 0);           cyc(1, 0, 8'h18, 0);
        dec(1, 3'd3, 1, 3'd0, 0, 3'd0, 0);           cyc(1, 0, 8'h18, 0);
        dec(1, 3'd3, 1, 3'd0, 0, 3'd0, 0); wb(3'd3); cyc(1, 0, 8'h18, 0);
        dec(1, 3'd3, 1, 3'd0, 0, 3'd0, 0);           cyc(0, 1, 8'h10, 0);
        wb(3'd4);                                    cyc(0, 0, 8'h10, 0);
        // 3: saturation on r5
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1);           cyc(0, 1, 8'h00, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1);           cyc(0, 1, 8'h20, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1);           cyc(0, 1, 8'h20, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1);           cyc(1, 0, 8'h20, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1); wb(3'd5); cyc(1, 0, 8'h20, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1);           cyc(0, 1, 8'h20, 0);
        // three retires drain exactly to zero
        wb(3'd5);                                    cyc(0, 0, 8'h20, 0);
        wb(3'd5);                                    cyc(0, 0, 8'h20, 0);
        wb(3'd5);                                    cyc(0, 0, 8'h20, 0);
        cyc(0, 0, 8'h00, 0);
        // 4: same-cycle issue and retire on r6 keeps count at 1
        dec(1, 3'd0, 0, 3'd0, 0, 3'd6, 1);           cyc(0, 1, 8'h00, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd6, 1); wb(3'd6); cyc(0, 1, 8'h40, 0);
        wb(3'd6);                                    cyc(0, 0, 8'h40, 0);
        cyc(0, 0, 8'h00, 0);
        // 5: different indices update independently; build pending on 1, 2, 5
        dec(1, 3'd0, 0, 3'd0, 0, 3'd1, 1);           cyc(0, 1, 8'h00, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd2, 1); wb(3'd1); cyc(0, 1, 8'h02, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd5, 1);           cyc(0, 1, 8'h04, 0);
        dec(1, 3'd0, 0, 3'd0, 0, 3'd1, 1);           cyc(0, 1, 8'h24, 0);
        // flush with an unrecorded issue and a zero-count retire that must not set sb_err
        dec(1, 3'd0, 0, 3'd0, 0, 3'd7, 1); wb(3'd3); flush = 1'b1; cyc(0, 1, 8'h26, 0);
        dec(1, 3'd1, 1, 3'd0, 0, 3'd0, 0);           cyc(0, 1, 8'h00, 0);
        // 6: retire of an idle register sets sticky sb_err
        wb(3'd7);                                    cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        // 7: unused sources and invalid decode never stall
        dec(1, 3'd0, 0, 3'd0, 0, 3'd2, 1);           cyc(0, 1, 8'h00, 1);
        dec(1, 3'd2, 0, 3'd2, 0, 3'd0, 0);           cyc(0, 1, 8'h04, 1);
        dec(0, 3'd2, 1, 3'd0, 0, 3'd2, 1);           cyc(0, 0, 8'h04, 1);
        cyc(0, 0, 8'h04, 1);
        dec(1, 3'd0, 0, 3'd2, 1, 3'd0, 0);           cyc(1, 0, 8'h04, 1);
        // 8: mid-operation reset clears counters and sb_err
        rst_n = 1'b0;                                cyc_nc();
        dec(1, 3'd2, 1, 3'd0, 0, 3'd0, 0);           cyc(0, 1, 8'h00, 0);

        repeat (2) @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain queue left %0d want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Pending-write scoreboard for the in-order pipeline; it is the producer-side counterpart of the decode-stage dependency check. Decode records each destination register as it issues an instruction, and writeback clears that record as the instruction retires. The block raises `D_stall` while a decode source (or a saturated destination) has an outstanding write. The stall replaces per-stage destination comparison with per-register pending counters, so any pipeline depth is tracked correctly.

## Interface
Parameters:
- `NUM_REGS`, 8: number of architectural registers.
- `IDX_W`, 3: register index width; `NUM_REGS` = 2^`IDX_W`.
- `CNT_W`, 2: pending-counter width; maximum in-flight writes per register is 2^`CNT_W`-1 = 3.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `D_valid`  in  1  decode holds a valid instruction requesting issue.
- `D_src1_idx`  in  `IDX_W`  source 1 register.
- `D_src1_use`  in  1  source 1 is read.
- `D_src2_idx`  in  `IDX_W`  source 2 register.
- `D_src2_use`  in  1  source 2 is read.
- `D_dst_idx`  in  `IDX_W`  destination register.
- `D_dst_we`  in  1  instruction writes `D_dst_idx`.
- `WB_valid`  in  1  writeback retires a register write this cycle.
- `WB_dst_idx`  in  `IDX_W`  register being written back.
- `flush`  in  1  pipeline flush; discard all pending records.
- `D_stall`  out  1  decode must hold; issue is not recorded.
- `D_issue`  out  1  `D_valid & ~D_stall`; the issue is recorded this cycle.
- `pending_mask`  out  `NUM_REGS`  bit r = counter[r] != 0 (registered state view).
- `sb_err`  out  1  sticky: retire of a register whose counter is 0.

## Operation
- State: `NUM_REGS` counters `cnt[r]` of width `CNT_W`, plus the `sb_err` flop.
- Hazard terms, all from registered counters only (no WB-to-decode bypass):
  - src1 hazard = `D_src1_use & cnt[D_src1_idx]!=0`.
  - src2 hazard = `D_src2_use & cnt[D_src2_idx]!=0`.
  - saturation = `D_dst_we & cnt[D_dst_idx]==max`.
- `D_stall = D_valid & (src1 hazard | src2 hazard | saturation)`. It is 0 whenever `D_valid`=0.
- Counter update per register r, each cycle:
  - inc = `D_issue & D_dst_we & D_dst_idx==r`.
  - dec = `WB_valid & WB_dst_idx==r & cnt[r]!=0`.
  - inc & dec: hold. inc only: +1. dec only: -1. Neither: hold.
- Retire with `cnt[WB_dst_idx]`==0: counter stays 0 and `sb_err` sets. `sb_err` is cleared only by reset.
- `flush`=1: all counters go to 0 next cycle, overriding inc/dec. `D_issue` still reflects the combinational value but is not recorded. `sb_err` is unaffected, and a retire during flush does not set it.
- WAW is allowed: repeated issues to the same destination increment up to max. The counter never wraps, because saturation forces a stall.

## Timing
- Reset (`rst_n`=0 at a rising edge): all `cnt`=0, `pending_mask`=0, `sb_err`=0.
  - `D_stall`=0 and `D_issue`=`D_valid` in the cycle after reset.
- Reset mid-operation discards all pending records, with the same values as above.
- Issue latency: a recorded issue at edge N is visible in `pending_mask` and `D_stall` from edge N onward, i.e. for the next decode instruction.
- Retire latency: a retire at edge N clears the hazard from edge N onward. A decode instruction waiting on that register issues in the cycle after WB_valid, not the same cycle.
- Same-cycle issue and retire of the same index: the net count is unchanged.
- Same-cycle issue and retire of different indices: both counters update independently.
- Outputs `pending_mask` and `sb_err` come directly from flops. `D_stall` and `D_issue` are combinational from the inputs and the flops.

## Test plan
- Reset, then `D_valid`=1, src1=1, src2=2, dst=4, `D_dst_we`=1 -> `D_stall`=0, `D_issue`=1. Next cycle `pending_mask`=8'h10.
- Issue dst=3; next cycle decode src1=3 -> `D_stall`=1 each cycle until `WB_valid`,`WB_dst_idx`=3. Stall is still 1 in the WB cycle, and 0 the cycle after with `pending_mask[3]`=0.
- Three issues to dst=5 with no retire -> `cnt[5]`=3. Fourth issue to dst=5 -> `D_stall`=1 (saturation), `cnt` stays 3. After one retire of 5, the fourth issue proceeds.
- `cnt[6]`=1. Same cycle: issue dst=6 and retire 6 -> `cnt[6]`=1 afterwards. Separately, retire 7 with `cnt[7]`=0 -> `sb_err`=1, held until `rst_n`=0.
- Pending on registers 1, 2 and 5, then assert `flush` -> next cycle `pending_mask`=0. Decode src1=1 -> `D_stall`=0.
- `D_src1_use`=0 with src1 pending -> `D_stall`=0. `D_valid`=0 with a hazard present -> `D_stall`=0, `D_issue`=0, no counter change.
